// File: rtl/risc_v_mike_fetch_unit_if.sv
// Fetch-stage bus: redirect input, combinational imem port, and the decode-facing valid/ready head.
// master = fetch unit, slave = surrounding pipeline/memory.
interface risc_v_mike_fetch_unit_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_rd_data;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_pc_plus4;
   logic [31:0] fetch_instr;
   logic        fetch_fault;

   modport master (
      input  redirect_valid, redirect_pc, imem_rd_data, fetch_ready,
      output imem_addr, fetch_valid, fetch_pc, fetch_pc_plus4, fetch_instr, fetch_fault
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_rd_data, fetch_ready,
      input  imem_addr, fetch_valid, fetch_pc, fetch_pc_plus4, fetch_instr, fetch_fault
   );
endinterface

// File: rtl/risc_v_mike_fetch_unit.sv
// Instruction fetch: owns the PC, captures imem words into a 2-entry queue, one-cycle fetch latency.
// Decode backpressure fills the queue then stalls the PC; a redirect flushes and costs one bubble.
module risc_v_mike_fetch_unit #(
   parameter logic [31:0] TEXT_BASE  = 32'h0040_0000,
   parameter int unsigned TEXT_DEPTH = 1024,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic                        clk,
   input  logic                        rst,
   risc_v_mike_fetch_unit_if.master    bus
);

   typedef logic [31:0] t_pc_addr;

   typedef struct packed {
      t_pc_addr    pc;
      logic [31:0] instr;
      logic        fault;
   } t_entry;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } t_mode;

   localparam t_pc_addr TEXT_BYTES = t_pc_addr'(TEXT_DEPTH * 4);

   t_pc_addr   pc_q, pc_d;
   t_entry     entry_q [2];
   t_entry     entry_d [2];
   logic [1:0] count_q, count_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic       wr_ptr_q, wr_ptr_d;
   t_mode      mode_q, mode_d;

   logic       fault;
   logic       pop;
   logic       push;
   t_entry     new_entry;
   t_entry     head;
   logic       head_vld;

   // Unsigned subtraction makes addresses below TEXT_BASE wrap high and fault too.
   assign fault = (pc_q[1:0] != 2'b00) || ((pc_q - TEXT_BASE) >= TEXT_BYTES);

   assign head_vld = (count_q != 2'd0);
   assign pop      = head_vld & bus.fetch_ready;
   assign push     = (mode_q == RUN) & ~bus.redirect_valid & ((count_q < 2'd2) | pop);

   assign new_entry.pc    = pc_q;
   assign new_entry.instr = fault ? NOP_INSTR : bus.imem_rd_data;
   assign new_entry.fault = fault;

   always_comb begin
      pc_d       = pc_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      mode_d     = mode_q;
      entry_d[0] = entry_q[0];
      entry_d[1] = entry_q[1];

      if (bus.redirect_valid) begin
         pc_d     = bus.redirect_pc;
         count_d  = 2'd0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         mode_d   = RUN;
      end else begin
         if (push) begin
            entry_d[wr_ptr_q] = new_entry;
            wr_ptr_d          = ~wr_ptr_q;
            if (fault) begin
               mode_d = HALT;
            end else begin
               pc_d = pc_q + 32'd4;
            end
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q       <= TEXT_BASE;
         count_q    <= 2'd0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         mode_q     <= RUN;
         entry_q[0] <= '0;
         entry_q[1] <= '0;
      end else begin
         pc_q       <= pc_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         mode_q     <= mode_d;
         entry_q[0] <= entry_d[0];
         entry_q[1] <= entry_d[1];
      end
   end

   // Head outputs depend only on registered state, never on imem data or ready.
   assign head = entry_q[rd_ptr_q];

   assign bus.imem_addr      = pc_q;
   assign bus.fetch_valid    = head_vld;
   assign bus.fetch_pc       = head_vld ? head.pc    : 32'd0;
   assign bus.fetch_instr    = head_vld ? head.instr : 32'd0;
   assign bus.fetch_fault    = head_vld ? head.fault : 1'b0;
   assign bus.fetch_pc_plus4 = bus.fetch_pc + 32'd4;

endmodule

// File: tb/tb_risc_v_mike_fetch_unit.sv
// Directed bench for the fetch unit; a behavioural imem supplies known words per address.
module tb_risc_v_mike_fetch_unit;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   risc_v_mike_fetch_unit_if bus();

   risc_v_mike_fetch_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] imem_word(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - 32'h0040_0000;
      if (off == 32'd0)      return 32'h0fc1_0417;
      else if (off == 32'd4) return 32'h0244_0493;
      else if (off < 32'd4096 && addr[1:0] == 2'b00) return 32'h1000_0000 + (off >> 2);
      else return 32'hdead_beef;
   endfunction

   always_comb bus.imem_rd_data = imem_word(bus.imem_addr);

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_head(input string tag, input logic vld, input logic [31:0] pc,
                             input logic [31:0] instr, input logic flt);
      check_val({tag, "_vld"},   32'(bus.fetch_valid), 32'(vld));
      check_val({tag, "_pc"},    bus.fetch_pc, pc);
      check_val({tag, "_instr"}, bus.fetch_instr, instr);
      check_val({tag, "_fault"}, 32'(bus.fetch_fault), 32'(flt));
      check_val({tag, "_pc4"},   bus.fetch_pc_plus4, pc + 32'd4);
   endtask

   task automatic do_reset(input logic rdy);
      rst                = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'd0;
      bus.fetch_ready    = rdy;
      tick(2);
      rst = 1'b1;
   endtask

   task automatic redirect_to(input logic [31:0] target);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = target;
      tick(1);
      bus.redirect_valid = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;

      // Reset values
      do_reset(1'b1);
      check_head("rst", 1'b0, 32'd0, 32'd0, 1'b0);
      check_val("rst_addr", bus.imem_addr, 32'h0040_0000);

      // Streaming fetch, one per cycle
      tick(1);
      check_head("s0", 1'b1, 32'h0040_0000, 32'h0fc1_0417, 1'b0);
      check_val("s0_addr", bus.imem_addr, 32'h0040_0004);
      tick(1);
      check_head("s1", 1'b1, 32'h0040_0004, 32'h0244_0493, 1'b0);

      // Backpressure: queue saturates, PC holds
      do_reset(1'b0);
      tick(5);
      check_val("bp_addr", bus.imem_addr, 32'h0040_0008);
      check_head("bp_h0", 1'b1, 32'h0040_0000, 32'h0fc1_0417, 1'b0);
      bus.fetch_ready = 1'b1;
      tick(1);
      check_head("bp_h1", 1'b1, 32'h0040_0004, 32'h0244_0493, 1'b0);
      tick(1);
      check_head("bp_h2", 1'b1, 32'h0040_0008, 32'h1000_0002, 1'b0);
      tick(1);
      check_head("bp_h3", 1'b1, 32'h0040_000c, 32'h1000_0003, 1'b0);

      // Redirect with full queue
      do_reset(1'b0);
      tick(2);
      redirect_to(32'h0040_0024);
      check_val("rd_vld", 32'(bus.fetch_valid), 32'd0);
      check_val("rd_addr", bus.imem_addr, 32'h0040_0024);
      bus.fetch_ready = 1'b1;
      tick(1);
      check_head("rd_tgt", 1'b1, 32'h0040_0024, 32'h1000_0009, 1'b0);

      // Misaligned redirect: one faulted entry, then halt
      redirect_to(32'h0040_0002);
      tick(1);
      check_head("mis", 1'b1, 32'h0040_0002, 32'h0000_0013, 1'b1);
      tick(1);
      check_val("mis_drain", 32'(bus.fetch_valid), 32'd0);
      tick(4);
      check_val("halt_vld", 32'(bus.fetch_valid), 32'd0);
      check_val("halt_addr", bus.imem_addr, 32'h0040_0002);
      redirect_to(32'h0040_0000);
      tick(1);
      check_head("resume", 1'b1, 32'h0040_0000, 32'h0fc1_0417, 1'b0);

      // End of text segment
      redirect_to(32'h0040_0ffc);
      tick(1);
      check_head("end_ok", 1'b1, 32'h0040_0ffc, 32'h1000_03ff, 1'b0);
      tick(1);
      check_head("end_flt", 1'b1, 32'h0040_1000, 32'h0000_0013, 1'b1);
      check_val("end_addr", bus.imem_addr, 32'h0040_1000);
      tick(2);
      check_val("end_halt", 32'(bus.fetch_valid), 32'd0);
      check_val("end_hold", bus.imem_addr, 32'h0040_1000);

      // Mid-stream reset overrides a concurrent redirect
      redirect_to(32'h0040_0010);
      tick(2);
      rst                = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0040_0024;
      tick(1);
      check_head("mrst", 1'b0, 32'd0, 32'd0, 1'b0);
      check_val("mrst_addr", bus.imem_addr, 32'h0040_0000);
      rst                = 1'b1;
      bus.redirect_valid = 1'b0;
      tick(1);
      check_head("mrst_run", 1'b1, 32'h0040_0000, 32'h0fc1_0417, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
